// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, the "no register"
// marker and the memory-access FSM state encoding.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [1:0] FSM_IDLE   = 2'd0;
    localparam logic [1:0] FSM_ACCESS = 2'd1;
    localparam logic [1:0] FSM_DONE   = 2'd2;

    function automatic logic is_read_op(input logic [3:0] icode);
        return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
    endfunction

    function automatic logic is_write_op(input logic [3:0] icode);
        return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
    endfunction

endpackage

// File: rtl/memory_access_fsm.sv
// Data-memory req/ready handshake: IDLE -> ACCESS -> DONE with registered request
// fields and captured response. MEM_STAGE_TIMEOUT_EN adds an ACCESS-cycle watchdog.
module memory_access_fsm
    import y86_pkg::*;
`ifdef MEM_STAGE_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we_in,
    input  logic [63:0] addr_in,
    input  logic [63:0] wdata_in,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ready,
    input  logic        dmem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        in_access,
    output logic        in_done,
    output logic [63:0] cap_data,
    output logic        cap_err
);

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            FSM_IDLE: begin
                if (start) begin
                    state_d = FSM_ACCESS;
                    req_d   = 1'b1;
                    we_d    = we_in;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    data_d  = '0;
                    err_d   = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            FSM_ACCESS: begin
                // A faulted or write access returns no load data.
                if (dmem_ready) begin
                    state_d = FSM_DONE;
                    req_d   = 1'b0;
                    data_d  = (!we_q && !dmem_err) ? dmem_rdata : '0;
                    err_d   = dmem_err;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FSM_DONE;
                    req_d   = 1'b0;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            FSM_DONE: state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FSM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign in_access  = (state_q == FSM_ACCESS);
    assign in_done    = (state_q == FSM_DONE);
    assign cap_data   = data_q;
    assign cap_err    = err_q;

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: icode decode, address select, bounds check and output
// muxing around memory_access_fsm. Optional watchdog: MEM_STAGE_TIMEOUT_EN.
module memory_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = 64'd8192
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    output logic [2:0]  m_stat,
    output logic [3:0]  m_icode,
    output logic [63:0] m_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_destE,
    output logic [3:0]  m_destM,
    output logic        m_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ready,
    input  logic        dmem_err
);

    logic        is_read, is_write, is_mem, bad_addr, start;
    logic [63:0] addr_sel;
    logic        in_access, in_done, cap_err;
    logic [63:0] cap_data;

    // popq/ret address through valA (old %rsp); everything else uses valE.
    assign is_read  = is_read_op(M_icode);
    assign is_write = is_write_op(M_icode);
    assign is_mem   = is_read || is_write;
    assign addr_sel = (M_icode == ICODE_POPQ || M_icode == ICODE_RET) ? M_valA : M_valE;
    assign bad_addr = is_mem && (addr_sel >= MEM_SIZE);
    assign start    = is_mem && (M_stat == STAT_AOK) && !bad_addr;

    memory_access_fsm
`ifdef MEM_STAGE_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
        u_fsm (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .we_in      (is_write),
        .addr_in    (addr_sel),
        .wdata_in   (M_valA),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .dmem_err   (dmem_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .in_access  (in_access),
        .in_done    (in_done),
        .cap_data   (cap_data),
        .cap_err    (cap_err)
    );

    assign m_icode = M_icode;
    assign m_valE  = M_valE;
    assign m_destE = M_dstE;
    assign m_destM = M_dstM;

    always_comb begin
        m_stall = 1'b0;
        m_stat  = M_stat;
        m_valM  = '0;
        if (in_access) begin
            m_stall = 1'b1;
        end else if (in_done) begin
            m_stat = cap_err ? STAT_ADR : M_stat;
            m_valM = cap_data;
        end else begin
            m_stall = start;
            if (bad_addr) begin
                m_stat = STAT_ADR;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, randomized ops
// against a rule-level reference model, reset and stall/timeout sequences.
module tb_memory_stage;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        int          lat;
        logic [63:0] rdata;
        logic        err;
        logic        exp_start;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [2:0]  exp_stat;
        logic [63:0] exp_valm;
    } vec_t;

    logic        clk, rst;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode, m_destE, m_destM;
    logic [63:0] m_valE, m_valM;
    logic        m_stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready, dmem_err;

    int total = 0;
    int bad = 0;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .m_stat     (m_stat),
        .m_icode    (m_icode),
        .m_valE     (m_valE),
        .m_valM     (m_valM),
        .m_destE    (m_destE),
        .m_destM    (m_destM),
        .m_stall    (m_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .dmem_err   (dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] stat, input logic [3:0] icode,
                                input logic [63:0] val_e, input logic [63:0] val_a,
                                input logic [3:0] dst_e, input logic [3:0] dst_m,
                                input int lat, input logic [63:0] rdata, input logic err,
                                input logic exp_start, input logic exp_we,
                                input logic [63:0] exp_addr, input logic [2:0] exp_stat,
                                input logic [63:0] exp_valm);
        vec_t v;
        v.stat = stat; v.icode = icode; v.val_e = val_e; v.val_a = val_a;
        v.dst_e = dst_e; v.dst_m = dst_m; v.lat = lat; v.rdata = rdata; v.err = err;
        v.exp_start = exp_start; v.exp_we = exp_we; v.exp_addr = exp_addr;
        v.exp_stat = exp_stat; v.exp_valm = exp_valm;
        return v;
    endfunction

    // Reference model: expected results derived straight from the instruction rules.
    function automatic vec_t refModel(input logic [2:0] stat, input logic [3:0] icode,
                                      input logic [63:0] val_e, input logic [63:0] val_a,
                                      input logic [3:0] dst_e, input logic [3:0] dst_m,
                                      input int lat, input logic [63:0] rdata, input logic err);
        int ic;
        bit rd, wr, in_range;
        logic [63:0] a;
        vec_t v;
        ic = int'(icode);
        rd = (ic == 5) || (ic == 11) || (ic == 9);
        wr = (ic == 4) || (ic == 10) || (ic == 8);
        a = (ic == 9 || ic == 11) ? val_a : val_e;
        in_range = (a < 64'd8192);
        v = mk(stat, icode, val_e, val_a, dst_e, dst_m, lat, rdata, err,
               1'b0, wr, a, stat, 64'd0);
        if (rd || wr) begin
            if (!in_range) v.exp_stat = 3'd3;
            else if (stat == 3'd1) begin
                v.exp_start = 1'b1;
                v.exp_stat = err ? 3'd3 : 3'd1;
                v.exp_valm = (rd && !err) ? rdata : 64'd0;
            end
        end
        return v;
    endfunction

    task automatic checkPass(input vec_t v, input string tag);
        checkOutput({tag, "_icode"}, m_icode, v.icode);
        checkOutput({tag, "_valE"}, m_valE, v.val_e);
        checkOutput({tag, "_destE"}, m_destE, v.dst_e);
        checkOutput({tag, "_destM"}, m_destM, v.dst_m);
    endtask

    // Entered just after a rising edge with the stage in IDLE; leaves it the same way.
    task automatic applyStimulus(input vec_t v);
        M_stat = v.stat; M_icode = v.icode; M_valE = v.val_e; M_valA = v.val_a;
        M_dstE = v.dst_e; M_dstM = v.dst_m;
        dmem_ready = 1'b1; dmem_err = 1'b1; dmem_rdata = 64'hBAD0BAD0;
        @(negedge clk);
        checkPass(v, "idle");
        checkOutput("idle_stall", m_stall, v.exp_start);
        checkOutput("idle_req", dmem_req, 1'b0);
        if (!v.exp_start) begin
            checkOutput("pass_stat", m_stat, v.exp_stat);
            checkOutput("pass_valM", m_valM, 64'd0);
            @(posedge clk); #1;
            dmem_ready = 1'b0; dmem_err = 1'b0;
        end else begin
            for (int k = 1; k <= v.lat; k++) begin
                @(posedge clk); #1;
                dmem_ready = (k == v.lat);
                dmem_err = v.err && (k == v.lat);
                dmem_rdata = v.rdata;
                @(negedge clk);
                checkOutput("acc_req", dmem_req, 1'b1);
                checkOutput("acc_we", dmem_we, v.exp_we);
                checkOutput("acc_addr", dmem_addr, v.exp_addr);
                checkOutput("acc_wdata", dmem_wdata, v.val_a);
                checkOutput("acc_stall", m_stall, 1'b1);
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0; dmem_err = 1'b0;
            @(negedge clk);
            checkPass(v, "done");
            checkOutput("done_stall", m_stall, 1'b0);
            checkOutput("done_req", dmem_req, 1'b0);
            checkOutput("done_stat", m_stat, v.exp_stat);
            checkOutput("done_valM", m_valM, v.exp_valm);
            @(posedge clk); #1;
        end
    endtask

    vec_t table_v[11];

    initial begin
        table_v[0]  = mk(1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h3, 3, 64'hDEAD, 0, 1, 0, 64'h100, 1, 64'hDEAD);
        table_v[1]  = mk(1, 4'hA, 64'h1F8, 64'h55, 4'h4, 4'hF, 1, 64'h9999, 0, 1, 1, 64'h1F8, 1, 64'h0);
        table_v[2]  = mk(1, 4'hB, 64'h200, 64'd8192, 4'h4, 4'h1, 1, 64'h0, 0, 0, 0, 64'h0, 3, 64'h0);
        table_v[3]  = mk(2, 4'h4, 64'h10, 64'h22, 4'hF, 4'hF, 1, 64'h0, 0, 0, 1, 64'h0, 2, 64'h0);
        table_v[4]  = mk(1, 4'h5, 64'h20, 64'h0, 4'hF, 4'h6, 1, 64'h1234, 1, 1, 0, 64'h20, 3, 64'h0);
        table_v[5]  = mk(1, 4'h3, 64'h7, 64'h0, 4'h2, 4'hF, 1, 64'h0, 0, 0, 0, 64'h0, 1, 64'h0);
        table_v[6]  = mk(1, 4'h9, 64'h2000, 64'h1FF8, 4'h4, 4'hF, 2, 64'h40, 0, 1, 0, 64'h1FF8, 1, 64'h40);
        table_v[7]  = mk(1, 4'h8, 64'h1FF8, 64'h77, 4'h4, 4'hF, 2, 64'h0, 0, 1, 1, 64'h1FF8, 1, 64'h0);
        table_v[8]  = mk(1, 4'h5, 64'd8191, 64'h0, 4'hF, 4'h7, 1, 64'h5, 0, 1, 0, 64'd8191, 1, 64'h5);
        table_v[9]  = mk(1, 4'h4, 64'd8192, 64'h3, 4'hF, 4'hF, 1, 64'h0, 0, 0, 1, 64'h0, 3, 64'h0);
        table_v[10] = mk(4, 4'hB, 64'h18, 64'h10, 4'h4, 4'h2, 1, 64'h0, 0, 0, 0, 64'h0, 4, 64'h0);

        rst = 1'b1;
        M_stat = 3'd1; M_icode = 4'h1; M_valE = 64'h0; M_valA = 64'h0;
        M_dstE = 4'hF; M_dstM = 4'hF;
        dmem_ready = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'h0;
        #3;
        checkOutput("rst_req", dmem_req, 1'b0);
        checkOutput("rst_we", dmem_we, 1'b0);
        checkOutput("rst_addr", dmem_addr, 64'h0);
        checkOutput("rst_wdata", dmem_wdata, 64'h0);
        checkOutput("rst_stall", m_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++) applyStimulus(table_v[i]);

        $display("[TB] random vectors");
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  s;
            logic [63:0] ve, va;
            s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            ve = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8300));
            va = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8300));
            applyStimulus(refModel(s, 4'($urandom_range(0, 11)), ve, va,
                                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                   int'($urandom_range(1, 4)), {$urandom, $urandom},
                                   1'($urandom_range(0, 5) == 0)));
        end

        // Reset while an access is outstanding must drop the request immediately.
        $display("[TB] reset mid-access");
        M_stat = 3'd1; M_icode = 4'h5; M_valE = 64'h80; M_valA = 64'h0;
        dmem_ready = 1'b0; dmem_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_req", dmem_req, 1'b1);
        rst = 1'b1;
        M_icode = 4'h1;
        #1;
        checkOutput("mid_rst_req", dmem_req, 1'b0);
        checkOutput("mid_rst_addr", dmem_addr, 64'h0);
        checkOutput("mid_rst_stall", m_stall, 1'b0);
        checkOutput("mid_rst_icode", m_icode, 64'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_rst_req", dmem_req, 1'b0);
        @(posedge clk); #1;

`ifdef MEM_STAGE_TIMEOUT_EN
        $display("[TB] timeout");
        M_stat = 3'd1; M_icode = 4'h5; M_valE = 64'h40;
        dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("to_idle_stall", m_stall, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("to_req", dmem_req, 1'b1);
            checkOutput("to_stall", m_stall, 1'b1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("to_done_req", dmem_req, 1'b0);
        checkOutput("to_done_stall", m_stall, 1'b0);
        checkOutput("to_done_stat", m_stat, 3'd3);
        checkOutput("to_done_valM", m_valM, 64'h0);
        @(posedge clk); #1;
`else
        $display("[TB] long wait");
        M_stat = 3'd1; M_icode = 4'h5; M_valE = 64'h40;
        dmem_ready = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("wait_req", dmem_req, 1'b1);
        checkOutput("wait_stall", m_stall, 1'b1);
        @(posedge clk); #1;
        dmem_ready = 1'b1; dmem_rdata = 64'hCAFE;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("wait_done_stall", m_stall, 1'b0);
        checkOutput("wait_done_valM", m_valM, 64'hCAFE);
        checkOutput("wait_done_stat", m_stat, 3'd1);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
